// File: rtl/keycode_pkg.sv
// Shared types and HID keycode constants for the keycode motion scheduler.
package keycode_pkg;

   // Direction command encoding seen by the ball motion logic.
   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_LEFT  = 3'd2,
      DIR_DOWN  = 3'd3,
      DIR_RIGHT = 3'd4
   } dir_t;

   // HID usage codes for W/A/S/D and the keyboard rollover error code.
   localparam logic [7:0] KC_W        = 8'h1A;
   localparam logic [7:0] KC_A        = 8'h04;
   localparam logic [7:0] KC_S        = 8'h16;
   localparam logic [7:0] KC_D        = 8'h07;
   localparam logic [7:0] KC_ROLLOVER = 8'h01;

   // Per-frame scheduler states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_ISSUE   = 2'd3
   } state_t;

endpackage

// File: rtl/keycode_decode.sv
// Combinational decode of one HID keycode byte into a direction / rollover flag.
module keycode_decode
   import keycode_pkg::*;
(
   input  logic [7:0] kc_byte,
   output logic       is_dir,
   output logic [2:0] dir,
   output logic       is_rollover
);

   // Map WASD to directions; flag the rollover error code; everything else is ignored.
   always_comb begin
      is_dir      = 1'b0;
      dir         = DIR_NONE;
      is_rollover = 1'b0;
      case (kc_byte)
         KC_W:        begin is_dir = 1'b1; dir = DIR_UP;    end
         KC_A:        begin is_dir = 1'b1; dir = DIR_LEFT;  end
         KC_S:        begin is_dir = 1'b1; dir = DIR_DOWN;  end
         KC_D:        begin is_dir = 1'b1; dir = DIR_RIGHT; end
         KC_ROLLOVER: is_rollover = 1'b1;
         default:     ;
      endcase
   end

endmodule

// File: rtl/keycode_motion_scheduler.sv
// Per-frame motion command scheduler: snapshots the keycode words on each
// frame start, scans the eight bytes one per cycle, resolves one direction and
// offers it to the ball motion logic over a valid/ready handshake.
//
// Handshake: cmd_valid rises with cmd_dir already stable and both hold until a
// cycle where cmd_valid && cmd_ready; that cycle is the transfer and cmd_valid
// drops on the following cycle. cmd_ready has no effect while cmd_valid is low.
module keycode_motion_scheduler
   import keycode_pkg::*;
#(
   parameter bit VS_ACTIVE_LOW = 1'b1,
   parameter int OVR_W         = 8,
   parameter bit STICKY_DIR    = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             vs,
   input  logic [31:0]      keycode0,
   input  logic [31:0]      keycode1,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [2:0]       cmd_dir,
   output logic             frame_tick,
   output logic             busy,
   output logic [OVR_W-1:0] overrun_cnt
);

   state_t           state_q, state_d;
   logic             vs_q, vs_d;
   logic [63:0]      snap_q, snap_d;
   logic [2:0]       idx_q, idx_d;
   logic             found_q, found_d;
   logic             rollover_q, rollover_d;
   dir_t             rec_dir_q, rec_dir_d;
   dir_t             held_dir_q, held_dir_d;
   dir_t             cmd_dir_q, cmd_dir_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             frame_tick_q, frame_tick_d;
   logic [OVR_W-1:0] ovr_q, ovr_d;

   logic             frame_edge;
   logic [7:0]       cur_byte;
   logic             dec_is_dir;
   logic [2:0]       dec_dir;
   logic             dec_is_rollover;
   dir_t             resolved_dir;

   // Frame start: previous vs at the inactive level, current vs at the active level.
   assign frame_edge = ((vs ^ VS_ACTIVE_LOW) == 1'b1) && ((vs_q ^ VS_ACTIVE_LOW) == 1'b0);

   // Byte under scan from the snapshot; byte 0 is keycode0[7:0].
   assign cur_byte = snap_q[{idx_q, 3'b000} +: 8];

   keycode_decode u_decode (
      .kc_byte     (cur_byte),
      .is_dir      (dec_is_dir),
      .dir         (dec_dir),
      .is_rollover (dec_is_rollover)
   );

   // Rollover keeps the previous direction; otherwise the first WASD wins,
   // and with no key pressed the sticky option decides.
   always_comb begin
      resolved_dir = DIR_NONE;
      if (rollover_q)      resolved_dir = held_dir_q;
      else if (found_q)    resolved_dir = rec_dir_q;
      else if (STICKY_DIR) resolved_dir = held_dir_q;
   end

   // Next-state logic for the scheduler FSM, snapshot, outputs and overrun counter.
   always_comb begin
      state_d      = state_q;
      vs_d         = vs;
      snap_d       = snap_q;
      idx_d        = idx_q;
      found_d      = found_q;
      rollover_d   = rollover_q;
      rec_dir_d    = rec_dir_q;
      held_dir_d   = held_dir_q;
      cmd_dir_d    = cmd_dir_q;
      cmd_valid_d  = cmd_valid_q;
      frame_tick_d = frame_edge;
      ovr_d        = ovr_q;

      // A frame start outside IDLE is dropped and counted, saturating.
      if (frame_edge && (state_q != ST_IDLE) && (ovr_q != {OVR_W{1'b1}})) begin
         ovr_d = ovr_q + OVR_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_edge) begin
               snap_d     = {keycode1, keycode0};
               idx_d      = 3'd0;
               found_d    = 1'b0;
               rollover_d = 1'b0;
               state_d    = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (dec_is_rollover) begin
               rollover_d = 1'b1;
            end else if (dec_is_dir && !found_q) begin
               rec_dir_d = dir_t'(dec_dir);
               found_d   = 1'b1;
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = ST_RESOLVE;
         end
         ST_RESOLVE: begin
            held_dir_d  = resolved_dir;
            cmd_dir_d   = resolved_dir;
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All scheduler state and registered outputs; reset discards any pending command.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         vs_q         <= VS_ACTIVE_LOW;
         snap_q       <= '0;
         idx_q        <= 3'd0;
         found_q      <= 1'b0;
         rollover_q   <= 1'b0;
         rec_dir_q    <= DIR_NONE;
         held_dir_q   <= DIR_NONE;
         cmd_dir_q    <= DIR_NONE;
         cmd_valid_q  <= 1'b0;
         frame_tick_q <= 1'b0;
         ovr_q        <= '0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs_d;
         snap_q       <= snap_d;
         idx_q        <= idx_d;
         found_q      <= found_d;
         rollover_q   <= rollover_d;
         rec_dir_q    <= rec_dir_d;
         held_dir_q   <= held_dir_d;
         cmd_dir_q    <= cmd_dir_d;
         cmd_valid_q  <= cmd_valid_d;
         frame_tick_q <= frame_tick_d;
         ovr_q        <= ovr_d;
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_dir     = cmd_dir_q;
   assign frame_tick  = frame_tick_q;
   assign busy        = (state_q != ST_IDLE);
   assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_keycode_motion_scheduler.sv
// Bench for keycode_motion_scheduler: a sticky instance (OVR_W=8) and a
// non-sticky instance (OVR_W=3) share one stimulus stream; a timeline model
// predicts both every cycle, and directed frames pin literal expectations.
module tb_keycode_motion_scheduler;

   logic        clk;
   logic        reset_n;
   logic        vs;
   logic [31:0] keycode0;
   logic [31:0] keycode1;
   logic        cmd_ready;

   logic        valid0, valid1;
   logic [2:0]  dir0, dir1;
   logic        tick0, tick1;
   logic        busy0, busy1;
   logic [7:0]  ovr0;
   logic [2:0]  ovr1;

   int checks = 0;
   int errors = 0;

   keycode_motion_scheduler #(.VS_ACTIVE_LOW(1'b1), .OVR_W(8), .STICKY_DIR(1'b1)) dut_s (
      .clk(clk), .reset_n(reset_n), .vs(vs), .keycode0(keycode0), .keycode1(keycode1),
      .cmd_ready(cmd_ready), .cmd_valid(valid0), .cmd_dir(dir0), .frame_tick(tick0),
      .busy(busy0), .overrun_cnt(ovr0)
   );

   keycode_motion_scheduler #(.VS_ACTIVE_LOW(1'b1), .OVR_W(3), .STICKY_DIR(1'b0)) dut_n (
      .clk(clk), .reset_n(reset_n), .vs(vs), .keycode0(keycode0), .keycode1(keycode1),
      .cmd_ready(cmd_ready), .cmd_valid(valid1), .cmd_dir(dir1), .frame_tick(tick1),
      .busy(busy1), .overrun_cnt(ovr1)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Direction chosen for a frame from the snapshot words, the previously
   // issued direction and the sticky option.
   function automatic int decide(input logic [31:0] k0, input logic [31:0] k1,
                                 input int held, input int sticky);
      logic [63:0] all_b;
      logic [7:0]  b;
      int          found;
      bit          roll;
      all_b = {k1, k0};
      found = -1;
      roll  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b = all_b[i*8 +: 8];
         if (b == 8'h01) roll = 1'b1;
         else if (found < 0) begin
            if (b == 8'h1A) found = 1;
            else if (b == 8'h04) found = 2;
            else if (b == 8'h16) found = 3;
            else if (b == 8'h07) found = 4;
         end
      end
      if (roll) return held;
      if (found >= 0) return found;
      return (sticky != 0) ? held : 0;
   endfunction

   int m_busy[2], m_valid[2], m_dir[2], m_held[2], m_ovr[2], m_tick[2], m_cnt[2], m_res[2];
   int m_vsp = 1;
   int m_sticky[2] = '{1, 0};
   int m_ovr_max[2] = '{255, 7};

   // Timeline model: frame accepted in IDLE -> valid 10 cycles later until ready.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_valid[i] = 0; m_dir[i] = 0; m_held[i] = 0;
            m_ovr[i] = 0; m_tick[i] = 0; m_cnt[i] = 0; m_res[i] = 0;
         end
         m_vsp = 1;
      end else begin
         bit fe;
         fe = (m_vsp == 1) && (vs == 1'b0);
         for (int i = 0; i < 2; i++) begin
            m_tick[i] = fe ? 1 : 0;
            if (m_busy[i] == 0) begin
               if (fe) begin
                  m_busy[i] = 1;
                  m_cnt[i]  = 1;
                  m_res[i]  = decide(keycode0, keycode1, m_held[i], m_sticky[i]);
               end
            end else begin
               if (fe && m_ovr[i] < m_ovr_max[i]) m_ovr[i]++;
               if (m_valid[i] != 0) begin
                  if (cmd_ready) begin
                     m_valid[i] = 0;
                     m_busy[i]  = 0;
                  end
               end else begin
                  m_cnt[i]++;
                  if (m_cnt[i] == 10) begin
                     m_valid[i] = 1;
                     m_dir[i]   = m_res[i];
                     m_held[i]  = m_res[i];
                  end
               end
            end
         end
         m_vsp = vs;
      end
   end

   // Scoreboard compare, every cycle, away from the active edge
   always @(posedge clk) begin
      #2;
      chk("valid_s", valid0, m_valid[0]);
      chk("dir_s",   dir0,   m_dir[0]);
      chk("tick_s",  tick0,  m_tick[0]);
      chk("busy_s",  busy0,  m_busy[0]);
      chk("ovr_s",   ovr0,   m_ovr[0]);
      chk("valid_n", valid1, m_valid[1]);
      chk("dir_n",   dir1,   m_dir[1]);
      chk("tick_n",  tick1,  m_tick[1]);
      chk("busy_n",  busy1,  m_busy[1]);
      chk("ovr_n",   ovr1,   m_ovr[1]);
   end

   // ---------------- driver tasks ----------------
   // One frame with ready high; checks latency, both directions and the return to IDLE.
   task automatic run_frame(input logic [31:0] k0, input logic [31:0] k1,
                            input int exp_s, input int exp_n, input string tag);
      int lat;
      @(negedge clk);
      keycode0  = k0;
      keycode1  = k1;
      cmd_ready = 1'b1;
      vs        = 1'b0;
      @(posedge clk); #2;
      chk({tag, "_tick"}, tick0, 1);
      @(negedge clk);
      vs = 1'b1;
      lat = 1;
      while (!valid0 && lat < 30) begin
         @(posedge clk); #2;
         lat++;
      end
      chk({tag, "_latency"}, lat, 10);
      chk({tag, "_dir_s"}, dir0, exp_s);
      chk({tag, "_dir_n"}, dir1, exp_n);
      @(posedge clk); #2;
      chk({tag, "_valid_low"}, valid0, 0);
      chk({tag, "_busy_low"}, busy0, 0);
      repeat (2) @(posedge clk);
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] tbl [6];
      tbl = '{8'h00, 8'h01, 8'h1A, 8'h04, 8'h16, 8'h07};
      if ($urandom_range(0, 5) == 0) return 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) return 8'h00;
      return tbl[$urandom_range(0, 5)];
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int ticks;
      reset_n   = 1'b0;
      vs        = 1'b1;
      keycode0  = '0;
      keycode1  = '0;
      cmd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", valid0, 0);
      chk("rst_dir",   dir0,   0);
      chk("rst_busy",  busy0,  0);
      chk("rst_ovr",   ovr0,   0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Basic W frame, then lowest index wins, then byte 4
      run_frame(32'h0000001A, 32'h0, 1, 1, "w_frame");
      run_frame(32'h00070004, 32'h0, 2, 2, "a_before_d");
      run_frame(32'h0, 32'h00000016, 3, 3, "s_byte4");
      // Sticky vs non-sticky with no key pressed
      run_frame(32'h00000007, 32'h0, 4, 4, "d_frame");
      run_frame(32'h0, 32'h0, 4, 0, "no_key");
      // Rollover holds the previous direction despite W in byte 0
      run_frame(32'h00000004, 32'h0, 2, 2, "a_frame");
      run_frame(32'h0000011A, 32'h0, 2, 2, "rollover");

      // Back-pressure across three more frame starts
      @(negedge clk);
      cmd_ready = 1'b0;
      keycode0  = 32'h00000007;
      vs        = 1'b0;
      @(negedge clk);
      vs = 1'b1;
      begin
         int w;
         w = 0;
         while (!valid0 && w < 30) begin
            @(posedge clk); #2;
            w++;
         end
         chk("bp_valid_seen", valid0, 1);
      end
      ticks = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         vs = ((c % 4) == 0) ? 1'b0 : 1'b1;
         @(posedge clk); #2;
         if (tick0) ticks++;
         chk("bp_hold_valid", valid0, 1);
         chk("bp_hold_dir", dir0, 4);
      end
      chk("bp_ticks", ticks, 3);
      chk("bp_ovr_s", ovr0, 3);
      chk("bp_ovr_n", ovr1, 3);
      @(negedge clk);
      cmd_ready = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("bp_drained_valid", valid0, 0);
      chk("bp_drained_busy", busy0, 0);

      // Reset in the middle of a scan
      @(negedge clk);
      keycode0 = 32'h00000016;
      vs       = 1'b0;
      @(posedge clk); #2;
      @(negedge clk);
      vs = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", valid0, 0);
      chk("midrst_dir",   dir0,   0);
      chk("midrst_busy",  busy0,  0);
      chk("midrst_tick",  tick0,  0);
      chk("midrst_ovr",   ovr0,   0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #2;
         chk("midrst_no_cmd", valid0, 0);
      end
      run_frame(32'h0000001A, 32'h0, 1, 1, "post_rst");

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         cmd_ready = ($urandom_range(0, 3) != 0);
         if (vs == 1'b0) begin
            vs = 1'b1;
         end else if ($urandom_range(0, 15) == 0) begin
            vs       = 1'b0;
            keycode0 = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
            keycode1 = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
         end
      end

      // Saturation burst on the narrow counter
      @(negedge clk);
      cmd_ready = 1'b0;
      vs        = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         vs = ~vs;
      end
      @(negedge clk);
      vs = 1'b1;
      @(posedge clk); #2;
      chk("sat_ovr_n", ovr1, 7);
      @(negedge clk);
      cmd_ready = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      chk("end_idle", busy0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
